// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared decimal-arithmetic constants and types for the serial
//            BCD subtractor (digit type, radix constants, FSM state encoding).
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam int BCD_MAX   = 9;
  localparam int BCD_RADIX = 10;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/bcd_sub_serial_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_sub_serial_if
// Purpose  : Operand/result handshake bundle for the serial BCD subtractor.
//            master = producer/consumer side, slave = the subtractor.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_sub_serial_if #(
  parameter int NDIGITS = 4
);
  localparam int DW = 4 * NDIGITS;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          bin;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] diff;
  logic          bout;
  logic          err;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, err
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, err
  );
endinterface
`default_nettype wire

// File: rtl/bcd_digit_sub.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_sub
// Purpose  : Combinational single-digit BCD subtract cell: d = a - b - bin,
//            with ten's-complement wrap and a borrow out. Flags non-BCD input.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  wire digit_t a_d,
  input  wire digit_t b_d,
  input  wire logic   bin,
  output digit_t      d,
  output logic        bout,
  output logic        dig_err
);

  logic [4:0] t;

  // 5-bit two's-complement difference; bit 4 set means the digit went negative,
  // in which case adding the radix (mod 16) yields the wrapped decimal digit.
  always_comb begin
    t       = {1'b0, a_d} - {1'b0, b_d} - {4'd0, bin};
    bout    = t[4];
    d       = t[4] ? (t[3:0] + 4'(BCD_RADIX)) : t[3:0];
    dig_err = (a_d > 4'(BCD_MAX)) || (b_d > 4'(BCD_MAX));
  end

endmodule
`default_nettype wire

// File: rtl/bcd_sub_serial.sv
`default_nettype none
// ============================================================================
// Module   : bcd_sub_serial
// Purpose  : Digit-serial packed-BCD subtractor, A - B - bin, one digit per
//            clock LSD first, with valid/ready operand and result handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_sub_serial
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  bcd_sub_serial_if.slave bus
);

  localparam int DW    = 4 * NDIGITS;
  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIGITS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    a_sh_q, a_sh_d;
  logic [DW-1:0]    b_sh_q, b_sh_d;
  logic             borrow_q, borrow_d;
  logic [DW-1:0]    diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             err_q, err_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  digit_t           w_d;
  logic             w_bout;
  logic             w_err;

  // The current digit always sits in the low nibble of the shift registers.
  bcd_digit_sub u_digit (
    .a_d     (a_sh_q[3:0]),
    .b_d     (b_sh_q[3:0]),
    .bin     (borrow_q),
    .d       (w_d),
    .bout    (w_bout),
    .dig_err (w_err)
  );

  // Next-state and next-output logic; handshake outputs follow the next state
  // so that in_ready/out_valid are registered and never both high.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          borrow_d = bus.bin;
          diff_d   = '0;
          bout_d   = 1'b0;
          err_d    = 1'b0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        diff_d[4*cnt_q +: 4] = w_d;
        a_sh_d   = a_sh_q >> 4;
        b_sh_d   = b_sh_q >> 4;
        borrow_d = w_bout;
        err_d    = err_q | w_err;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          bout_d  = w_bout;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      borrow_q    <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      borrow_q    <= borrow_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_sub_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_sub_serial
// Purpose  : Self-checking bench for bcd_sub_serial (NDIGITS=4) with a
//            result scoreboard fed by the driver and drained by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_sub_serial;

  localparam int ND = 4;
  localparam int DW = 4 * ND;

  typedef struct packed {
    logic [DW-1:0] diff;
    logic          bout;
    logic          err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_sub_serial_if #(.NDIGITS(ND)) bus();

  bcd_sub_serial #(.NDIGITS(ND)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%h required=none", bus.diff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("diff", 32'(bus.diff), 32'(e.diff));
        chk("bout", 32'(bus.bout), 32'(e.bout));
        chk("err",  32'(bus.err),  32'(e.err));
      end
    end
  end

  // Handshake outputs must be mutually exclusive.
  always @(negedge clk) begin
    if (rst_n && bus.in_ready === 1'b1 && bus.out_valid === 1'b1) begin
      errors++;
      $display("FAIL ready_valid_overlap actual=1 required=0");
    end
  end

  // Issue one operation, queue its expected result, and check result latency.
  task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic bin,
                       input logic [DW-1:0] ed, input logic eb, input logic ee);
    int   k;
    bit   got;
    exp_t e;
    @(negedge clk);
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=%b required=1", bus.in_ready);
      return;
    end
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    bus.in_valid = 1'b1;
    e.diff = ed;
    e.bout = eb;
    e.err  = ee;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 16'h7777;
    bus.b        = 16'h3333;
    bus.bin      = 1'b1;
    got = 1'b0;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("latency", got ? 32'(k) : 32'd99, 32'(ND));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_diff",      32'(bus.diff),      32'd0);
    chk("rst_bout",      32'(bus.bout),      32'd0);
    chk("rst_err",       32'(bus.err),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vectors
    do_op(16'h5432, 16'h1234, 1'b0, 16'h4198, 1'b0, 1'b0);
    do_op(16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 1'b0);
    do_op(16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0);
    do_op(16'h0005, 16'h0005, 1'b1, 16'h9999, 1'b1, 1'b0);
    do_op(16'h9999, 16'h9999, 1'b0, 16'h0000, 1'b0, 1'b0);
    do_op(16'h000A, 16'h0000, 1'b0, 16'h000A, 1'b0, 1'b1);
    do_op(16'h2000, 16'h0999, 1'b0, 16'h1001, 1'b0, 1'b0);

    // Backpressure: hold the result, ignore operand offers
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    do_op(16'h7531, 16'h2468, 1'b0, 16'h5063, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      chk("bp_diff",      32'(bus.diff),      32'h5063);
      chk("bp_bout",      32'(bus.bout),      32'd0);
      chk("bp_err",       32'(bus.err),       32'd0);
      bus.a        = 16'h1111;
      bus.b        = 16'h0001;
      bus.in_valid = (i % 2 == 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_release_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    chk("bp_after_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_after_ready", 32'(bus.in_ready),  32'd1);

    // Reset in the middle of RUN (while digit 2 is being processed)
    @(negedge clk);
    bus.a        = 16'h00AB;
    bus.b        = 16'h0000;
    bus.bin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("run_err_before_rst", 32'(bus.err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_diff",      32'(bus.diff),      32'd0);
    chk("midrst_err",       32'(bus.err),       32'd0);
    chk("midrst_in_ready",  32'(bus.in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0100, 16'h0001, 1'b0, 16'h0099, 1'b0, 1'b0);

    repeat (6) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
